led_breath_sched: RTL and testbench

- Sequencing controller for the 8-bit brightness-ramp datapath.
- Walks a triangle breath (0→255, hold, 255→0, hold) across a set of LED channels in round-robin order.
- Generates each channel's PWM output from the shared ramp level.
- Sits between the board control/config registers and the LED pins, so the ramp is time-shared between channels rather than duplicated.

---
 rtl/led_breath_sched_pkg.sv | 48 ++++
 rtl/led_breath_sched_pwm_gen.sv | 41 ++++
 rtl/led_breath_sched.sv | 199 +++++++++++++++++++
 tb/tb_led_breath_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_breath_sched_pkg.sv
// Shared definitions for the LED breath scheduler.
//   state_t        : sequencer state encoding (3 bits)
//   LEVEL_MAX/MIN  : ramp end points
//   next_set_bit() : next set mask bit above an index; wraps to the lowest set bit
package led_breath_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4,
    ST_NEXT    = 3'd5
  } state_t;

  localparam logic [7:0] LEVEL_MAX = 8'd255;
  localparam logic [7:0] LEVEL_MIN = 8'd0;

  typedef struct packed {
    logic       wrap;  // no set bit above the index; idx holds the lowest set bit
    logic [2:0] idx;
  } bit_sel_t;

  // Searching from index 7 always wraps, so the same search yields the lowest set bit.
  function automatic bit_sel_t next_set_bit(input logic [7:0] mask, input logic [2:0] from);
    bit_sel_t   r;
    logic       found;
    logic [2:0] above;
    logic [2:0] lowest;
    found  = 1'b0;
    above  = 3'd0;
    lowest = 3'd0;
    // Scan downwards so the last hit is the lowest qualifying bit.
    for (int j = 7; j >= 0; j--) begin
      if (mask[j]) begin
        lowest = 3'(j);
        if (j > int'(from)) begin
          above = 3'(j);
          found = 1'b1;
        end
      end
    end
    r.wrap = ~found;
    r.idx  = found ? above : lowest;
    return r;
  endfunction

endpackage

// File: rtl/led_breath_sched_pwm_gen.sv
// PWM generator shared by all LED channels.
//   clk, rst      : clock, async active-low reset
//   en            : drive enable; 0 forces every output low on the next clock
//   level         : shared ramp brightness
//   sel           : index of the channel allowed to toggle
//   pwm_out       : registered per-channel PWM drive
module led_pwm_gen #(
  parameter int N_CH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [7:0]      level,
  input  logic [2:0]      sel,
  output logic [N_CH-1:0] pwm_out
);
  import led_breath_sched_pkg::*;

  logic [7:0]      pwm_cnt;
  logic [N_CH-1:0] sel_oh;
  logic            duty_on;

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_CH; i++) sel_oh[i] = (sel == 3'(i));
  end

  // level == LEVEL_MIN never satisfies the compare, so 0% duty falls out naturally.
  assign duty_on = en && (level != LEVEL_MIN) && (pwm_cnt < level);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
      pwm_out <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_out <= duty_on ? sel_oh : '0;
    end
  end

endmodule

// File: rtl/led_breath_sched.sv
// Round-robin triangle-breath sequencer driving a shared 8-bit ramp.
//   clk, rst                  : clock, async active-low reset
//   en                        : level enable, 0 aborts to IDLE
//   start                     : pulse, begins a sequence from IDLE
//   cfg_mask/div/hold/cycles/loop : configuration, shadowed on accepted start
//   level, pwm_out, active_ch : ramp level, PWM drive, driven channel
//   busy, done                : not IDLE / end-of-single-pass pulse
//
// state      | meaning
// IDLE       | waiting for start
// RISE       | level ramps up one step per tick
// HOLD_HI    | hold at peak for hold+1 ticks
// FALL       | level ramps down one step per tick
// HOLD_LO    | hold at floor, then next breath or next channel
// NEXT       | one clock: pick next channel, wrap, or finish
module led_breath_sched #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [N_CH-1:0]  cfg_mask,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [7:0]       cfg_hold,
  input  logic [3:0]       cfg_cycles,
  input  logic             cfg_loop,
  output logic [7:0]       level,
  output logic [N_CH-1:0]  pwm_out,
  output logic [2:0]       active_ch,
  output logic             busy,
  output logic             done
);
  import led_breath_sched_pkg::*;

  state_t           state_q, state_d;
  logic [7:0]       level_q, level_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [3:0]       cyc_cnt_q, cyc_cnt_d;
  logic [2:0]       ch_q, ch_d;
  logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       cycles_q, cycles_d;
  logic             loop_q, loop_d;
  logic             done_q, done_d;

  logic             tick;
  logic [3:0]       cyc_last;
  logic [7:0]       srch_mask;
  logic [2:0]       srch_from;
  bit_sel_t         sel;

  assign busy     = (state_q != ST_IDLE);
  assign tick     = busy && (pre_cnt_q == div_q);
  assign cyc_last = (cycles_q == 4'd0) ? 4'd0 : cycles_q - 4'd1;

  // One search serves both the start (lowest bit of the incoming mask) and NEXT.
  assign srch_mask = (state_q == ST_IDLE) ? 8'(cfg_mask) : 8'(mask_q);
  assign srch_from = (state_q == ST_IDLE) ? 3'd7 : ch_q;
  assign sel       = next_set_bit(srch_mask, srch_from);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      level_q    <= '0;
      hold_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      ch_q       <= '0;
      pre_cnt_q  <= '0;
      mask_q     <= '0;
      div_q      <= '0;
      hold_q     <= '0;
      cycles_q   <= '0;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      hold_cnt_q <= hold_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      ch_q       <= ch_d;
      pre_cnt_q  <= pre_cnt_d;
      mask_q     <= mask_d;
      div_q      <= div_d;
      hold_q     <= hold_d;
      cycles_q   <= cycles_d;
      loop_q     <= loop_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    hold_cnt_d = hold_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    ch_d       = ch_q;
    pre_cnt_d  = pre_cnt_q;
    mask_d     = mask_q;
    div_d      = div_q;
    hold_d     = hold_q;
    cycles_d   = cycles_q;
    loop_d     = loop_q;
    done_d     = 1'b0;

    if (busy) pre_cnt_d = tick ? '0 : pre_cnt_q + DIV_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start && en && (cfg_mask != '0)) begin
          mask_d     = cfg_mask;
          div_d      = cfg_div;
          hold_d     = cfg_hold;
          cycles_d   = cfg_cycles;
          loop_d     = cfg_loop;
          level_d    = LEVEL_MIN;
          hold_cnt_d = '0;
          cyc_cnt_d  = '0;
          ch_d       = sel.idx;
          pre_cnt_d  = '0;
          state_d    = ST_RISE;
        end
      end
      ST_RISE: begin
        if (tick) begin
          if (level_q == LEVEL_MAX) begin
            hold_cnt_d = '0;
            state_d    = ST_HOLD_HI;
          end else begin
            level_d = level_q + 8'd1;
          end
        end
      end
      ST_HOLD_HI: begin
        if (tick) begin
          if (hold_cnt_q == hold_q) state_d = ST_FALL;
          else hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      ST_FALL: begin
        if (tick) begin
          if (level_q == LEVEL_MIN) begin
            hold_cnt_d = '0;
            state_d    = ST_HOLD_LO;
          end else begin
            level_d = level_q - 8'd1;
          end
        end
      end
      ST_HOLD_LO: begin
        if (tick) begin
          if (hold_cnt_q != hold_q) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end else if (cyc_cnt_q == cyc_last) begin
            state_d = ST_NEXT;
          end else begin
            cyc_cnt_d = cyc_cnt_q + 4'd1;
            state_d   = ST_RISE;
          end
        end
      end
      ST_NEXT: begin
        if (!sel.wrap || loop_q) begin
          ch_d      = sel.idx;
          cyc_cnt_d = '0;
          state_d   = ST_RISE;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Enable dropping overrides everything, including a pending done.
    if (!en) begin
      state_d = ST_IDLE;
      level_d = LEVEL_MIN;
      done_d  = 1'b0;
    end
  end

  assign level     = level_q;
  assign active_ch = ch_q;
  assign done      = done_q;

  led_pwm_gen #(.N_CH(N_CH)) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .en      (busy && en),
    .level   (level_q),
    .sel     (ch_q),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_led_breath_sched.sv
module tb_led_breath_sched;
  localparam int N_CH  = 4;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic [N_CH-1:0]  cfg_mask = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [7:0]       cfg_hold = '0;
  logic [3:0]       cfg_cycles = '0;
  logic             cfg_loop = 1'b0;
  logic [7:0]       level;
  logic [N_CH-1:0]  pwm_out;
  logic [2:0]       active_ch;
  logic             busy;
  logic             done;

  led_breath_sched #(.N_CH(N_CH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .cfg_mask(cfg_mask), .cfg_div(cfg_div), .cfg_hold(cfg_hold),
    .cfg_cycles(cfg_cycles), .cfg_loop(cfg_loop),
    .level(level), .pwm_out(pwm_out), .active_ch(active_ch),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { string tag; int val; } exp_t;
  exp_t sb[$];

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int obs);
    exp_t e;
    if (sb.size() == 0) chk_eq("sb_underflow", 1, 0);
    else begin
      e = sb.pop_front();
      chk_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic set_cfg(input logic [N_CH-1:0] m, input int d, input int h,
                         input int c, input logic lp);
    cfg_mask   = m;
    cfg_div    = DIV_W'(d);
    cfg_hold   = 8'(h);
    cfg_cycles = 4'(c);
    cfg_loop   = lp;
  endtask

  // Called at a negedge; returns at the negedge right after start is sampled.
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_level(input int val, input int budget);
    int n;
    n = 0;
    while (level != 8'(val) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (level != 8'(val)) chk_eq("wait_level_timeout", int'(level), val);
  endtask

  task automatic abort_seq;
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_k, done_cnt, ramp_err, other_hi, ch_a, ch_b;
    int lv4, lv7, lv8, peak_k, drop_k;
    int rises[$];
    int prev_lv, ch_bad, busy_low, hi_cnt;

    // Reset values
    repeat (3) @(negedge clk);
    sb_push("rst_level", 0); sb_push("rst_busy", 0); sb_push("rst_done", 0);
    sb_push("rst_pwm", 0);   sb_push("rst_ch", 0);
    sb_pop(level); sb_pop(busy); sb_pop(done); sb_pop(pwm_out); sb_pop(active_ch);
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);

    // Reset mid-RISE clears outputs immediately
    set_cfg(4'b0100, 0, 0, 1, 1'b0);
    pulse_start;
    wait_level(100, 300);
    sb_push("midrst_level", 0); sb_push("midrst_busy", 0);
    sb_push("midrst_pwm", 0);   sb_push("midrst_ch", 0);
    rst = 1'b0;
    #1;
    sb_pop(level); sb_pop(busy); sb_pop(pwm_out); sb_pop(active_ch);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    sb_push("postrst_busy", 0); sb_push("postrst_level", 0);
    sb_pop(busy); sb_pop(level);

    // Two-channel single pass, tick every clock
    set_cfg(4'b0101, 0, 0, 1, 1'b0);
    sb_push("ramp_err", 0);  sb_push("ch_first", 0);  sb_push("ch_second", 2);
    sb_push("other_pwm", 0); sb_push("done_cnt", 1);  sb_push("done_clk", 1030);
    sb_push("busy_end", 0);
    pulse_start;
    done_k = -1; done_cnt = 0; ramp_err = 0; other_hi = 0; ch_a = -1; ch_b = -1;
    for (int k = 0; k <= 1100; k++) begin
      if (k <= 255 && int'(level) != k) ramp_err++;
      if (k == 10) ch_a = int'(active_ch);
      if (k == 600) ch_b = int'(active_ch);
      if (pwm_out[1] || pwm_out[3]) other_hi++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      @(negedge clk);
    end
    sb_pop(ramp_err); sb_pop(ch_a); sb_pop(ch_b); sb_pop(other_hi);
    sb_pop(done_cnt); sb_pop(done_k); sb_pop(busy);

    // Prescaler div=3 with hold=2: 518 ticks per breath, plus NEXT clock
    set_cfg(4'b0001, 3, 2, 1, 1'b0);
    sb_push("div_lv_k4", 1);    sb_push("div_lv_k7", 1);   sb_push("div_lv_k8", 2);
    sb_push("peak_clk", 1020);  sb_push("first_fall_clk", 1040);
    sb_push("div_done_clk", 2073);
    pulse_start;
    lv4 = -1; lv7 = -1; lv8 = -1; peak_k = -1; drop_k = -1; done_k = -1;
    for (int k = 0; k <= 2100; k++) begin
      if (k == 4) lv4 = int'(level);
      if (k == 7) lv7 = int'(level);
      if (k == 8) lv8 = int'(level);
      if (peak_k < 0 && level == 8'd255) peak_k = k;
      if (peak_k >= 0 && drop_k < 0 && level == 8'd254) drop_k = k;
      if (done && done_k < 0) done_k = k;
      @(negedge clk);
    end
    sb_pop(lv4); sb_pop(lv7); sb_pop(lv8); sb_pop(peak_k); sb_pop(drop_k); sb_pop(done_k);

    // Single channel, looping, two breaths per pass, five passes
    set_cfg(4'b1000, 0, 0, 2, 1'b1);
    sb_push("loop_rises", 10); sb_push("loop_gap_breath", 514);
    sb_push("loop_gap_pass", 515); sb_push("loop_done", 0);
    sb_push("loop_ch_bad", 0); sb_push("loop_busy_low", 0);
    pulse_start;
    prev_lv = int'(level); done_cnt = 0; ch_bad = 0; busy_low = 0;
    for (int k = 0; k <= 5145; k++) begin
      if (prev_lv == 0 && level == 8'd1) rises.push_back(k);
      prev_lv = int'(level);
      if (done) done_cnt++;
      if (active_ch != 3'd3) ch_bad++;
      if (!busy) busy_low++;
      @(negedge clk);
    end
    sb_pop(rises.size());
    if (rises.size() >= 3) begin
      sb_pop(rises[1] - rises[0]);
      sb_pop(rises[2] - rises[1]);
    end else begin
      sb_pop(-1);
      sb_pop(-1);
    end
    sb_pop(done_cnt); sb_pop(ch_bad); sb_pop(busy_low);
    abort_seq;

    // Empty mask ignored; start while busy ignored
    set_cfg(4'b0000, 0, 0, 1, 1'b0);
    sb_push("mask0_busy", 0);
    pulse_start;
    sb_pop(busy);
    set_cfg(4'b0001, 0, 0, 1, 1'b0);
    pulse_start;
    wait_level(50, 100);
    sb_push("restart_level", 51); sb_push("restart_ch", 0);
    cfg_mask = 4'b0010;
    pulse_start;
    sb_pop(level); sb_pop(active_ch);
    abort_seq;

    // PWM duty at level 64 on channel 1
    set_cfg(4'b0010, 300, 0, 1, 1'b0);
    sb_push("pwm_ch", 1); sb_push("pwm_hi_cnt", 64); sb_push("pwm_other", 0);
    pulse_start;
    wait_level(64, 64 * 301 + 50);
    sb_pop(active_ch);
    @(negedge clk);
    hi_cnt = 0; other_hi = 0;
    for (int k = 0; k < 256; k++) begin
      if (pwm_out[1]) hi_cnt++;
      if (pwm_out[0] || pwm_out[2] || pwm_out[3]) other_hi++;
      @(negedge clk);
    end
    sb_pop(hi_cnt); sb_pop(other_hi);
    abort_seq;

    // Enable dropped during HOLD_HI
    set_cfg(4'b0001, 0, 200, 1, 1'b0);
    sb_push("abort_busy", 0); sb_push("abort_level", 0);
    sb_push("abort_pwm", 0);  sb_push("abort_done", 0);
    pulse_start;
    wait_level(255, 300);
    repeat (50) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    sb_pop(busy); sb_pop(level); sb_pop(pwm_out);
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    sb_pop(done_cnt);
    en = 1'b1;

    if (sb.size() != 0) chk_eq("sb_leftover", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
